// File: rtl/adc_pkg.sv
// Shared types and defaults for the intan stage sequencer.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_CONF,
    ST_READ,
    ST_DONE
  } stage_e;

  localparam int KIND_NULL = 0;
  localparam int NCH_DEF   = 4;
  localparam int KW_DEF    = 2;
  localparam int TMO_DEF   = 65535;

  function automatic logic is_stage(input stage_e s);
    return (s == ST_CHECK) || (s == ST_CONF) || (s == ST_READ);
  endfunction

endpackage

// File: rtl/adc_stage_timer.sv
// Saturating stage-cycle counter; expired marks the last cycle before a stage times out.
module adc_stage_timer
  import adc_pkg::*;
#(
  parameter int TMO = TMO_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  localparam int            CW   = $clog2(TMO);
  localparam logic [CW-1:0] LAST = CW'(TMO - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign every output a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/adc_seq.sv
// Stage sequencer: fans one upstream check/conf/read handshake out to NCH channels
// and folds their done levels back, masking empty or failed slots and timing out dead ones.
module adc_seq
  import adc_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int KW  = KW_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs_check,
  input  logic              fs_conf,
  input  logic              fs_read,
  output logic              fd_check,
  output logic              fd_conf,
  output logic              fd_read,
  output logic [NCH-1:0]    ch_fs_check,
  output logic [NCH-1:0]    ch_fs_conf,
  output logic [NCH-1:0]    ch_fs_read,
  input  logic [NCH-1:0]    ch_fd_check,
  input  logic [NCH-1:0]    ch_fd_conf,
  input  logic [NCH-1:0]    ch_fd_read,
  input  logic [NCH*KW-1:0] ch_kind,
  output logic [NCH*KW-1:0] dev_kind,
  output logic [NCH-1:0]    ch_err,
  output logic              err
);

  stage_e            state_q, state_d, stage_q, stage_d, fs_sel;
  logic [NCH-1:0]    ch_fs_q, ch_fs_d;
  logic              fd_q, fd_d, err_q, err_d;
  logic [NCH-1:0]    done_mask, err_mask, err_nx;
  logic [NCH*KW-1:0] kind_map;
  logic [NCH-1:0]    en, en_cfg, fd_cur, hit, done_nx;
  logic              fs_cur, in_stage, abort, upd, complete, timeout, expired;
  logic              start, start_check;

  adc_stage_timer #(.TMO(TMO)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_stage),
    .expired (expired)
  );

  always_comb begin
    fs_sel = ST_IDLE;
    if (fs_check)     fs_sel = ST_CHECK;
    else if (fs_conf) fs_sel = ST_CONF;
    else if (fs_read) fs_sel = ST_READ;
  end

  always_comb begin
    fs_cur = 1'b0;
    fd_cur = '0;
    unique case (stage_q)
      ST_CHECK: begin fs_cur = fs_check; fd_cur = ch_fd_check; end
      ST_CONF:  begin fs_cur = fs_conf;  fd_cur = ch_fd_conf;  end
      ST_READ:  begin fs_cur = fs_read;  fd_cur = ch_fd_read;  end
      default:  ;
    endcase
  end

  // A channel that answers on the timeout edge still counts as done.
  assign en          = (stage_q == ST_CHECK) ? '1 : en_cfg;
  assign hit         = en & fd_cur;
  assign done_nx     = done_mask | hit;
  assign complete    = &(done_nx | ~en);
  assign in_stage    = is_stage(state_q);
  assign abort       = in_stage && !fs_cur;
  assign upd         = in_stage && fs_cur;
  assign timeout     = upd && !complete && expired;
  assign start       = (state_q == ST_IDLE) && (fs_sel != ST_IDLE);
  assign start_check = (state_q == ST_IDLE) && (fs_sel == ST_CHECK);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic          done_q, done_d, err_q, err_d, lose;
    logic [KW-1:0] kind_q, kind_d;

    assign en_cfg[i] = (kind_q != KW'(KIND_NULL)) && !err_q;
    assign lose      = timeout && en[i] && !done_nx[i];

    always_comb begin
      done_d = done_q;
      kind_d = kind_q;
      err_d  = err_q;
      if (start)    done_d = 1'b0;
      else if (upd) done_d = done_nx[i];
      if (start_check) begin
        kind_d = KW'(KIND_NULL);
        err_d  = 1'b0;
      end else if (upd && (stage_q == ST_CHECK) && hit[i] && !done_q) begin
        kind_d = ch_kind[i*KW +: KW];
      end else if (lose) begin
        kind_d = KW'(KIND_NULL);
        err_d  = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        done_q <= 1'b0;
        kind_q <= KW'(KIND_NULL);
        err_q  <= 1'b0;
      end else begin
        done_q <= done_d;
        kind_q <= kind_d;
        err_q  <= err_d;
      end
    end

    assign done_mask[i]          = done_q;
    assign err_mask[i]           = err_q;
    assign err_nx[i]             = err_d;
    assign kind_map[i*KW +: KW]  = kind_q;
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    ch_fs_d = ch_fs_q;
    fd_d    = fd_q;
    err_d   = |err_nx;
    unique case (state_q)
      ST_IDLE: begin
        fd_d    = 1'b0;
        ch_fs_d = '0;
        if (start) begin
          state_d = fs_sel;
          stage_d = fs_sel;
          ch_fs_d = (fs_sel == ST_CHECK) ? '1 : en_cfg;
        end
      end
      ST_CHECK, ST_CONF, ST_READ: begin
        if (abort) begin
          state_d = ST_IDLE;
          ch_fs_d = '0;
        end else if (complete || timeout) begin
          state_d = ST_DONE;
          ch_fs_d = '0;
          fd_d    = 1'b1;
        end else begin
          ch_fs_d = en;
        end
      end
      ST_DONE: begin
        ch_fs_d = '0;
        if (!fs_cur) begin
          fd_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stage_q <= ST_IDLE;
      ch_fs_q <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      ch_fs_q <= ch_fs_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  // stage_q only changes while ch_fs_q and fd_q are low, so the gating cannot glitch.
  assign ch_fs_check = (stage_q == ST_CHECK) ? ch_fs_q : '0;
  assign ch_fs_conf  = (stage_q == ST_CONF)  ? ch_fs_q : '0;
  assign ch_fs_read  = (stage_q == ST_READ)  ? ch_fs_q : '0;
  assign fd_check    = fd_q && (stage_q == ST_CHECK);
  assign fd_conf     = fd_q && (stage_q == ST_CONF);
  assign fd_read     = fd_q && (stage_q == ST_READ);
  assign dev_kind    = kind_map;
  assign ch_err      = err_mask;
  assign err         = err_q;

endmodule

// File: tb/tb_adc_seq.sv
// Directed bench for adc_seq with NCH=4, KW=2, TMO=16.
module tb_adc_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       fs_check, fs_conf, fs_read;
  logic       fd_check, fd_conf, fd_read;
  logic [3:0] ch_fs_check, ch_fs_conf, ch_fs_read;
  logic [3:0] ch_fd_check, ch_fd_conf, ch_fd_read;
  logic [7:0] ch_kind, dev_kind;
  logic [3:0] ch_err;
  logic       err;
  int         total = 0;
  int         bad   = 0;

  adc_seq #(.NCH(4), .KW(2), .TMO(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .fs_check    (fs_check),
    .fs_conf     (fs_conf),
    .fs_read     (fs_read),
    .fd_check    (fd_check),
    .fd_conf     (fd_conf),
    .fd_read     (fd_read),
    .ch_fs_check (ch_fs_check),
    .ch_fs_conf  (ch_fs_conf),
    .ch_fs_read  (ch_fs_read),
    .ch_fd_check (ch_fd_check),
    .ch_fd_conf  (ch_fd_conf),
    .ch_fd_read  (ch_fd_read),
    .ch_kind     (ch_kind),
    .dev_kind    (dev_kind),
    .ch_err      (ch_err),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    fs_check = 1'b0; fs_conf = 1'b0; fs_read = 1'b0;
    ch_fd_check = '0; ch_fd_conf = '0; ch_fd_read = '0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({fd_check, fd_conf, fd_read, err} !== 4'b0000) begin
      bad++; $display("FAIL reset_fd_err: got %b want 0000", {fd_check, fd_conf, fd_read, err});
    end
    total++;
    if ({ch_fs_check, ch_fs_conf, ch_fs_read, ch_err, dev_kind} !== 24'h0) begin
      bad++; $display("FAIL reset_vec: got %h want 000000", {ch_fs_check, ch_fs_conf, ch_fs_read, ch_err, dev_kind});
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if ({ch_fs_check, ch_fs_conf, ch_fs_read, fd_check, fd_conf, fd_read} !== 15'h0) begin
      bad++; $display("FAIL post_reset_idle: got %h want 0", {ch_fs_check, ch_fs_conf, ch_fs_read, fd_check, fd_conf, fd_read});
    end
  endtask

  task automatic test_check_map();
    fs_check = 1'b1;
    tick();
    total++;
    if (ch_fs_check !== 4'b1111) begin
      bad++; $display("FAIL chk_fs: got %b want 1111", ch_fs_check);
    end
    total++;
    if ({ch_fs_conf, ch_fs_read} !== 8'h0) begin
      bad++; $display("FAIL chk_other_fs: got %b want 0", {ch_fs_conf, ch_fs_read});
    end
    tick();
    ch_fd_check = 4'b0001; ch_kind = 8'b00_00_00_11;
    tick();
    ch_fd_check = 4'b1111; ch_kind = 8'b01_10_00_00;
    total++;
    if (fd_check !== 1'b0) begin
      bad++; $display("FAIL chk_partial_fd: got %b want 0", fd_check);
    end
    total++;
    if (dev_kind !== 8'b00_00_00_11) begin
      bad++; $display("FAIL chk_first_latch: got %b want 00000011", dev_kind);
    end
    tick();
    total++;
    if ({fd_check, ch_fs_check} !== 5'b1_0000) begin
      bad++; $display("FAIL chk_done: got %b want 10000", {fd_check, ch_fs_check});
    end
    total++;
    if (dev_kind !== 8'b01_10_00_11) begin
      bad++; $display("FAIL chk_kind_map: got %b want 01100011", dev_kind);
    end
    total++;
    if ({err, ch_err} !== 5'b0) begin
      bad++; $display("FAIL chk_err: got %b want 00000", {err, ch_err});
    end
    fs_check = 1'b0; ch_fd_check = '0; ch_kind = '0;
    tick();
    total++;
    if (fd_check !== 1'b0) begin
      bad++; $display("FAIL chk_fd_drop: got %b want 0", fd_check);
    end
    tick();
  endtask

  task automatic test_conf_mask();
    fs_conf = 1'b1;
    tick();
    total++;
    if (ch_fs_conf !== 4'b1101) begin
      bad++; $display("FAIL conf_mask: got %b want 1101", ch_fs_conf);
    end
    ch_fd_conf = 4'b1111;
    tick();
    total++;
    if ({fd_conf, ch_fs_conf} !== 5'b1_0000) begin
      bad++; $display("FAIL conf_done: got %b want 10000", {fd_conf, ch_fs_conf});
    end
    release_all();
    tick();
    total++;
    if (fd_conf !== 1'b0) begin
      bad++; $display("FAIL conf_fd_drop: got %b want 0", fd_conf);
    end
    tick();
  endtask

  task automatic test_read_timeout();
    fs_read = 1'b1;
    tick();
    total++;
    if (ch_fs_read !== 4'b1101) begin
      bad++; $display("FAIL rd_mask: got %b want 1101", ch_fs_read);
    end
    ch_fd_read = 4'b1001;
    repeat (15) tick();
    total++;
    if ({fd_read, ch_err, ch_fs_read} !== 9'b0_0000_1101) begin
      bad++; $display("FAIL rd_pre_timeout: got %b want 000001101", {fd_read, ch_err, ch_fs_read});
    end
    tick();
    total++;
    if ({fd_read, err, ch_err, ch_fs_read} !== 10'b1_1_0100_0000) begin
      bad++; $display("FAIL rd_timeout: got %b want 1101000000", {fd_read, err, ch_err, ch_fs_read});
    end
    total++;
    if (dev_kind !== 8'b01_00_00_11) begin
      bad++; $display("FAIL rd_timeout_kind: got %b want 01000011", dev_kind);
    end
    release_all();
    tick();
    total++;
    if ({fd_read, ch_err} !== 5'b0_0100) begin
      bad++; $display("FAIL rd_err_sticky: got %b want 00100", {fd_read, ch_err});
    end
    tick();
    fs_conf = 1'b1;
    tick();
    total++;
    if (ch_fs_conf !== 4'b1001) begin
      bad++; $display("FAIL conf_after_err: got %b want 1001", ch_fs_conf);
    end
    ch_fd_conf = 4'b1001;
    tick();
    total++;
    if (fd_conf !== 1'b1) begin
      bad++; $display("FAIL conf_after_err_fd: got %b want 1", fd_conf);
    end
    release_all();
    tick();
    tick();
  endtask

  task automatic test_read_boundary();
    fs_read = 1'b1;
    tick();
    ch_fd_read = 4'b0001;
    repeat (15) tick();
    total++;
    if (fd_read !== 1'b0) begin
      bad++; $display("FAIL bnd_early_fd: got %b want 0", fd_read);
    end
    ch_fd_read = 4'b1001;
    tick();
    total++;
    if ({fd_read, ch_err} !== 5'b1_0100) begin
      bad++; $display("FAIL bnd_last_edge: got %b want 10100", {fd_read, ch_err});
    end
    total++;
    if (dev_kind !== 8'b01_00_00_11) begin
      bad++; $display("FAIL bnd_kind: got %b want 01000011", dev_kind);
    end
    release_all();
    tick();
    tick();
  endtask

  task automatic test_abort();
    fs_conf = 1'b1;
    tick();
    total++;
    if (ch_fs_conf !== 4'b1001) begin
      bad++; $display("FAIL abort_start: got %b want 1001", ch_fs_conf);
    end
    fs_check = 1'b1;
    tick();
    total++;
    if ({ch_fs_check, ch_fs_conf} !== 8'b0000_1001) begin
      bad++; $display("FAIL abort_ignore_other: got %b want 00001001", {ch_fs_check, ch_fs_conf});
    end
    fs_check = 1'b0; fs_conf = 1'b0;
    tick();
    total++;
    if ({fd_conf, ch_fs_conf} !== 5'b0) begin
      bad++; $display("FAIL abort_drop: got %b want 00000", {fd_conf, ch_fs_conf});
    end
    tick();
    total++;
    if ({fd_conf, ch_err, dev_kind} !== 13'b0_0100_01000011) begin
      bad++; $display("FAIL abort_state: got %b want 0010001000011", {fd_conf, ch_err, dev_kind});
    end
    fs_read = 1'b1;
    tick();
    total++;
    if (ch_fs_read !== 4'b1001) begin
      bad++; $display("FAIL abort_next_read: got %b want 1001", ch_fs_read);
    end
    ch_fd_read = 4'b1001;
    tick();
    total++;
    if (fd_read !== 1'b1) begin
      bad++; $display("FAIL abort_next_fd: got %b want 1", fd_read);
    end
    release_all();
    tick();
    tick();
  endtask

  task automatic test_check_timeout();
    fs_check = 1'b1;
    tick();
    total++;
    if ({err, ch_err, dev_kind, ch_fs_check} !== 17'b0_0000_00000000_1111) begin
      bad++; $display("FAIL chkto_entry: got %b want 00000000000001111", {err, ch_err, dev_kind, ch_fs_check});
    end
    repeat (15) tick();
    total++;
    if (fd_check !== 1'b0) begin
      bad++; $display("FAIL chkto_early: got %b want 0", fd_check);
    end
    tick();
    total++;
    if ({fd_check, err, ch_err, dev_kind} !== 14'b1_1_1111_00000000) begin
      bad++; $display("FAIL chkto_timeout: got %b want 11111100000000", {fd_check, err, ch_err, dev_kind});
    end
    release_all();
    tick();
    tick();
  endtask

  task automatic test_zero_enabled();
    fs_read = 1'b1;
    tick();
    total++;
    if ({fd_read, ch_fs_read} !== 5'b0) begin
      bad++; $display("FAIL zero_first: got %b want 00000", {fd_read, ch_fs_read});
    end
    tick();
    total++;
    if ({fd_read, ch_fs_read} !== 5'b1_0000) begin
      bad++; $display("FAIL zero_done: got %b want 10000", {fd_read, ch_fs_read});
    end
    release_all();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_read();
    fs_check = 1'b1;
    tick();
    ch_fd_check = 4'b1111; ch_kind = 8'b01_01_01_01;
    tick();
    total++;
    if ({fd_check, dev_kind, ch_err} !== 13'b1_01010101_0000) begin
      bad++; $display("FAIL rst_prep: got %b want 1010101010000", {fd_check, dev_kind, ch_err});
    end
    release_all();
    tick();
    tick();
    fs_read = 1'b1;
    tick();
    total++;
    if (ch_fs_read !== 4'b1111) begin
      bad++; $display("FAIL rst_read_fs: got %b want 1111", ch_fs_read);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({ch_fs_read, ch_fs_check, ch_fs_conf, dev_kind, ch_err} !== 24'h0) begin
      bad++; $display("FAIL rst_async_vec: got %h want 000000", {ch_fs_read, ch_fs_check, ch_fs_conf, dev_kind, ch_err});
    end
    total++;
    if ({fd_check, fd_conf, fd_read, err} !== 4'b0) begin
      bad++; $display("FAIL rst_async_fd: got %b want 0000", {fd_check, fd_conf, fd_read, err});
    end
    fs_read = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    fs_check = 1'b1;
    tick();
    total++;
    if (ch_fs_check !== 4'b1111) begin
      bad++; $display("FAIL rst_recheck_fs: got %b want 1111", ch_fs_check);
    end
    ch_fd_check = 4'b1111; ch_kind = 8'b11_10_01_11;
    tick();
    total++;
    if ({fd_check, dev_kind, err} !== 10'b1_11100111_0) begin
      bad++; $display("FAIL rst_recheck_done: got %b want 1111001110", {fd_check, dev_kind, err});
    end
    release_all();
    ch_kind = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ch_kind = '0;
    release_all();
    test_reset();
    test_check_map();
    test_conf_mask();
    test_read_timeout();
    test_read_boundary();
    test_abort();
    test_check_timeout();
    test_zero_enabled();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
